// File: rtl/audio_fifo_sched.sv
// Round-robin stereo sample scheduler feeding a FWFT FIFO, with prefill/stream/underrun playback control.
// Optional saturating drop counter output when AUDIO_FIFO_SCHED_DROP_CNT_EN is defined.
module audio_fifo_sched #(
    parameter int unsigned DATA    = 24,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned PREFILL = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_l,
    input  logic                       req_r,
    input  logic [DATA-1:0]            data_l,
    input  logic [DATA-1:0]            data_r,
    output logic                       ack_l,
    output logic                       ack_r,
    output logic                       fifo_write,
    output logic [DATA-1:0]            fifo_wdata,
    input  logic                       fifo_full,
    input  logic                       fifo_empty,
    output logic                       fifo_read,
    input  logic                       play_req,
    output logic                       play_valid,
    output logic [$clog2(DEPTH+1)-1:0] level,
`ifdef AUDIO_FIFO_SCHED_DROP_CNT_EN
    output logic [15:0]                drop_cnt,
`endif
    output logic [1:0]                 state,
    output logic                       underrun
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] LevelMax   = LW'(DEPTH);
    localparam logic [LW-1:0] PrefillLvl = LW'(PREFILL);

    typedef enum logic [1:0] {
        StPrefill  = 2'd0,
        StStream   = 2'd1,
        StUnderrun = 2'd2
    } state_e;

    state_e        state_q;
    logic          underrun_q;
    logic [LW-1:0] level_q, level_d;
    logic          last_right_q, last_right_d;
    logic          space;
    logic          grant_l, grant_r;

    // A read in the same cycle frees a slot even when the FIFO reports full.
    always_comb begin
        fifo_read = ~reset & play_req & (state_q == StStream) & ~fifo_empty;
        space     = ~fifo_full | fifo_read;
        grant_l   = ~reset & space & req_l & (~req_r | last_right_q);
        grant_r   = ~reset & space & req_r & (~req_l | ~last_right_q);
    end

    assign ack_l      = grant_l;
    assign ack_r      = grant_r;
    assign fifo_write = grant_l | grant_r;
    assign fifo_wdata = grant_r ? data_r : data_l;
    assign play_valid = fifo_read;
    assign level      = level_q;
    assign state      = state_q;
    assign underrun   = underrun_q;

    always_comb begin
        level_d      = level_q;
        last_right_d = last_right_q;
        if (grant_l) begin
            last_right_d = 1'b0;
        end else if (grant_r) begin
            last_right_d = 1'b1;
        end
        if (fifo_write && !fifo_read && (level_q < LevelMax)) begin
            level_d = level_q + 1'b1;
        end else if (fifo_read && !fifo_write && (level_q != '0)) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q      <= '0;
            last_right_q <= 1'b1;
        end else begin
            level_q      <= level_d;
            last_right_q <= last_right_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StPrefill;
            underrun_q <= 1'b0;
        end else begin
            case (state_q)
                StPrefill: begin
                    underrun_q <= 1'b0;
                    if (level_q >= PrefillLvl) begin
                        state_q <= StStream;
                    end
                end
                StStream: begin
                    if (play_req && fifo_empty) begin
                        state_q    <= StUnderrun;
                        underrun_q <= 1'b1;
                    end
                end
                StUnderrun: begin
                    state_q    <= StPrefill;
                    underrun_q <= 1'b0;
                end
                default: begin
                    state_q    <= StPrefill;
                    underrun_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef AUDIO_FIFO_SCHED_DROP_CNT_EN
    logic [15:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if ((req_l | req_r) && !(grant_l | grant_r) && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= 16'd0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_audio_fifo_sched.sv
// Directed self-checking bench for audio_fifo_sched with a behavioural FWFT FIFO occupancy model.
// Checks drop_cnt as well when AUDIO_FIFO_SCHED_DROP_CNT_EN is defined.
module tb_audio_fifo_sched;

    localparam int DATA  = 24;
    localparam int DEPTH = 8;

    logic            clk;
    logic            reset;
    logic            req_l, req_r;
    logic [DATA-1:0] data_l, data_r;
    logic            ack_l, ack_r;
    logic            fifo_write;
    logic [DATA-1:0] fifo_wdata;
    logic            fifo_full, fifo_empty;
    logic            fifo_read;
    logic            play_req;
    logic            play_valid;
    logic [3:0]      level;
    logic [1:0]      state;
    logic            underrun;
`ifdef AUDIO_FIFO_SCHED_DROP_CNT_EN
    logic [15:0]     drop_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int fcnt;

    audio_fifo_sched #(
        .DATA   (DATA),
        .DEPTH  (DEPTH),
        .PREFILL(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_l     (req_l),
        .req_r     (req_r),
        .data_l    (data_l),
        .data_r    (data_r),
        .ack_l     (ack_l),
        .ack_r     (ack_r),
        .fifo_write(fifo_write),
        .fifo_wdata(fifo_wdata),
        .fifo_full (fifo_full),
        .fifo_empty(fifo_empty),
        .fifo_read (fifo_read),
        .play_req  (play_req),
        .play_valid(play_valid),
        .level     (level),
`ifdef AUDIO_FIFO_SCHED_DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .state     (state),
        .underrun  (underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Attached FIFO occupancy, reset by the same reset as the DUT.
    assign fifo_full  = (fcnt == DEPTH);
    assign fifo_empty = (fcnt == 0);

    always @(posedge clk) begin
        if (reset) begin
            fcnt <= 0;
        end else begin
            fcnt <= fcnt + ((fifo_write && (fcnt < DEPTH || fifo_read)) ? 1 : 0)
                         - ((fifo_read && fcnt > 0) ? 1 : 0);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic l, input logic r, input logic [DATA-1:0] dl,
                         input logic [DATA-1:0] dr, input logic p);
        req_l    = l;
        req_r    = r;
        data_l   = dl;
        data_r   = dr;
        play_req = p;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(1'b1, 1'b0, 24'h0, 24'h0, 1'b1);
        tick();
        settle();
        check_eq("rst_ack_l", 32'(ack_l), 32'd0);
        check_eq("rst_write", 32'(fifo_write), 32'd0);
        check_eq("rst_read", 32'(fifo_read), 32'd0);
        drive(1'b0, 1'b0, 24'h0, 24'h0, 1'b0);
        tick();
        settle();
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_underrun", 32'(underrun), 32'd0);

        // Single left sample.
        reset = 1'b0;
        drive(1'b1, 1'b0, 24'h000001, 24'h0, 1'b0);
        settle();
        check_eq("one_ack_l", 32'(ack_l), 32'd1);
        check_eq("one_ack_r", 32'(ack_r), 32'd0);
        check_eq("one_write", 32'(fifo_write), 32'd1);
        check_eq("one_wdata", 32'(fifo_wdata), 32'h000001);
        tick();
        drive(1'b0, 1'b0, 24'h0, 24'h0, 1'b0);
        settle();
        check_eq("one_level", 32'(level), 32'd1);
        check_eq("one_state", 32'(state), 32'd0);

        // Fresh reset, then both sides pending: strict L,R alternation into a full FIFO.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, 1'b1, 24'h00000A, 24'h00000B, 1'b0);
        for (int i = 0; i < 8; i++) begin
            settle();
            check_eq("rr_ack_l", 32'(ack_l), (i % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("rr_ack_r", 32'(ack_r), (i % 2 == 1) ? 32'd1 : 32'd0);
            check_eq("rr_wdata", 32'(fifo_wdata), (i % 2 == 0) ? 32'hA : 32'hB);
            check_eq("rr_level", 32'(level), 32'(i));
            check_eq("rr_state", 32'(state), (i >= 5) ? 32'd1 : 32'd0);
            tick();
        end

        // Full with no consumer: both requests stall.
        for (int i = 0; i < 5; i++) begin
            settle();
            check_eq("full_ack_l", 32'(ack_l), 32'd0);
            check_eq("full_ack_r", 32'(ack_r), 32'd0);
            check_eq("full_write", 32'(fifo_write), 32'd0);
            check_eq("full_level", 32'(level), 32'd8);
            tick();
        end
        settle();
        check_eq("full_state", 32'(state), 32'd1);
`ifdef AUDIO_FIFO_SCHED_DROP_CNT_EN
        check_eq("drop_cnt", 32'(drop_cnt), 32'd5);
`endif

        // Full FIFO, read and write in the same cycle.
        drive(1'b1, 1'b0, 24'h00000C, 24'h0, 1'b1);
        settle();
        check_eq("rw_read", 32'(fifo_read), 32'd1);
        check_eq("rw_valid", 32'(play_valid), 32'd1);
        check_eq("rw_ack_l", 32'(ack_l), 32'd1);
        check_eq("rw_write", 32'(fifo_write), 32'd1);
        check_eq("rw_wdata", 32'(fifo_wdata), 32'hC);
        tick();
        drive(1'b0, 1'b0, 24'h0, 24'h0, 1'b1);
        settle();
        check_eq("rw_level", 32'(level), 32'd8);

        // Drain to level 2, then consume past empty into underrun.
        for (int i = 0; i < 6; i++) begin
            settle();
            check_eq("drain_read", 32'(fifo_read), 32'd1);
            tick();
        end
        settle();
        check_eq("drain_level", 32'(level), 32'd2);
        check_eq("drain_state", 32'(state), 32'd1);
        for (int i = 0; i < 2; i++) begin
            settle();
            check_eq("ur_read", 32'(fifo_read), 32'd1);
            tick();
        end
        settle();
        check_eq("ur_empty_read", 32'(fifo_read), 32'd0);
        check_eq("ur_empty_state", 32'(state), 32'd1);
        check_eq("ur_empty_pulse", 32'(underrun), 32'd0);
        tick();
        drive(1'b1, 1'b0, 24'h000055, 24'h0, 1'b1);
        settle();
        check_eq("ur_pulse", 32'(underrun), 32'd1);
        check_eq("ur_state", 32'(state), 32'd2);
        check_eq("ur_read_off", 32'(fifo_read), 32'd0);
        check_eq("ur_write_ack", 32'(ack_l), 32'd1);
        tick();
        drive(1'b0, 1'b0, 24'h0, 24'h0, 1'b1);
        settle();
        check_eq("post_ur_state", 32'(state), 32'd0);
        check_eq("post_ur_pulse", 32'(underrun), 32'd0);
        check_eq("post_ur_read", 32'(fifo_read), 32'd0);
        check_eq("post_ur_level", 32'(level), 32'd1);

        // Refill from the right to level 5, then reset with right still pending.
        drive(1'b0, 1'b1, 24'h0, 24'h000077, 1'b0);
        for (int i = 0; i < 4; i++) begin
            settle();
            check_eq("refill_ack_r", 32'(ack_r), 32'd1);
            tick();
        end
        settle();
        check_eq("refill_level", 32'(level), 32'd5);
        reset = 1'b1;
        settle();
        check_eq("mid_rst_ack_r", 32'(ack_r), 32'd0);
        check_eq("mid_rst_write", 32'(fifo_write), 32'd0);
        tick();
        reset = 1'b0;
        drive(1'b1, 1'b1, 24'h000011, 24'h000022, 1'b0);
        settle();
        check_eq("after_rst_level", 32'(level), 32'd0);
        check_eq("after_rst_state", 32'(state), 32'd0);
        check_eq("after_rst_ack_l", 32'(ack_l), 32'd1);
        check_eq("after_rst_ack_r", 32'(ack_r), 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/audio_fifo_sched.md
AUDIO_FIFO_SCHED -- requirements
Module: audio_fifo_sched

Interface
REQ-001 Parameter: DATA, default 24, sample width in bits.
REQ-002 Parameter: DEPTH, default 8, entries in the attached FIFO.
REQ-003 Parameter: PREFILL, default 4, occupancy required before playback starts (1..DEPTH).
REQ-004 Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 req_l / req_r  in  1 each  left/right sample pending; held high until the matching ack.
REQ-008 data_l / data_r  in  DATA each  left/right sample; stable while req high.
REQ-009 ack_l / ack_r  out  1 each  sample accepted this cycle; combinational.
REQ-010 fifo_write  out  1  FIFO write strobe.
REQ-011 fifo_wdata  out  DATA  FIFO write data.
REQ-012 fifo_full / fifo_empty  in  1 each  FIFO flags.
REQ-013 fifo_read  out  1  FIFO read strobe; FIFO is first-word-fall-through.
REQ-014 play_req  in  1  consumer requests one sample.
REQ-015 play_valid  out  1  FIFO read data is valid for the consumer this cycle.
REQ-016 level  out  $clog2(DEPTH+1)  tracked occupancy.
REQ-017 state  out  2  PREFILL=0, STREAM=1, UNDERRUN=2.
REQ-018 underrun  out  1  one-cycle pulse on underrun.

Function
REQ-019 fifo_read shall equal play_req & (state==STREAM) & ~fifo_empty; play_valid shall equal fifo_read.
REQ-020 Write space exists when ~fifo_full, or when fifo_full & fifo_read in the same cycle.
REQ-021 At most one write per cycle; with space, a lone requester is granted; with both requesting, grant goes to the side not granted last (round-robin); after reset, left wins first.
REQ-022 Granted side: ack asserted, fifo_write=1, fifo_wdata=its data, same cycle; the last-grant register updates on the next edge.
REQ-023 With no space: no ack, no write, requests held; no sample dropped or duplicated.
REQ-024 level shall be +1 on write only, -1 on read only, unchanged on both or neither; it shall never exceed DEPTH or go below 0.
REQ-025 PREFILL -> STREAM when registered level >= PREFILL; no reads in PREFILL.
REQ-026 STREAM -> UNDERRUN when play_req & fifo_empty; writes continue during UNDERRUN.
REQ-027 UNDERRUN -> PREFILL unconditionally next cycle; underrun=1 exactly while state==UNDERRUN.
REQ-028 In STREAM with level>0 and no play_req, the state shall be held.

Reset
REQ-029 On reset: state=PREFILL, level=0, last grant=right, underrun=0; all strobes and acks 0 that cycle.
REQ-030 Reset mid-operation shall abandon pending requests; the attached FIFO is reset by the same reset.

Configuration
REQ-031 Macro AUDIO_FIFO_SCHED_DROP_CNT_EN defined: add output drop_cnt (16 bits, reset 0) counting cycles where any req is high and no ack occurs; it saturates at 16'hFFFF.
REQ-032 Macro undefined: no drop_cnt port or logic; all other behaviour identical.

Verification
REQ-033 Reset, then req_l=1, data_l=0x000001, one cycle -> ack_l=1, fifo_write=1, fifo_wdata=0x000001, level=1 next cycle, state=PREFILL.
REQ-034 req_l and req_r held high with values 0xA/0xB, 8 cycles -> strict L,R,L,R alternation; state=STREAM the cycle after level reaches 4.
REQ-035 DEPTH=8 full, both reqs high, play_req=0 -> no ack for 5 cycles, level=8; with DROP_CNT_EN, drop_cnt=5.
REQ-036 Full FIFO, STREAM, play_req=1 and req_l=1 -> fifo_read=1, ack_l=1, fifo_write=1, level stays 8.
REQ-037 STREAM with level=2, play_req=1 for 3 cycles, no writes -> 2 reads, then underrun=1 for one cycle, then state=PREFILL, fifo_read=0.
REQ-038 Assert reset with level=5 and req_r high -> next cycle level=0, state=PREFILL, ack_r=0, left gets the next grant.
